// File: rtl/serial_carry_adder.sv
// Bit-serial (STEP bits per cycle) adder/subtractor with a valid/ready handshake on both sides.
// Operands shift out LSB-first while result bits shift into the top of the sum register.
module serial_carry_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry into slice MSB, carry out, STEP sum bits}; the carry into the
  // MSB is recovered from the MSB sum bit, so it is exact for any STEP.
  function automatic logic [STEP+1:0] step_add(
    input logic [STEP-1:0] x,
    input logic [STEP-1:0] y,
    input logic            c
  );
    logic [STEP:0] total;
    logic          msb_cin;
    total   = {1'b0, x} + {1'b0, y} + {{STEP{1'b0}}, c};
    msb_cin = x[STEP-1] ^ y[STEP-1] ^ total[STEP-1];
    return {msb_cin, total};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [STEP+1:0]       step_s;
  logic [WIDTH+STEP-1:0] sum_cat_s;
  logic [WIDTH-1:0]      sum_next_s;

  assign step_s     = step_add(a_r[STEP-1:0], b_r[STEP-1:0], carry_r);
  assign sum_cat_s  = {step_s[STEP-1:0], sum_r};
  assign sum_next_s = sum_cat_s[WIDTH+STEP-1:STEP];

  // Control FSM plus datapath registers; all outputs come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= sub ? ~b : b;
            carry_r    <= sub ? 1'b1 : cin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          a_r     <= a_r >> STEP;
          b_r     <= b_r >> STEP;
          sum_r   <= sum_next_s;
          carry_r <= step_s[STEP];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            cout_r      <= step_s[STEP];
            ovf_r       <= step_s[STEP+1] ^ step_s[STEP];
            zero_r      <= (sum_next_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          carry_r     <= 1'b0;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_carry_adder.sv
// Drives five serial_carry_adder configurations in lockstep and checks each
// against a plain-arithmetic reference model.
module tb_serial_carry_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_in;
  logic       out_ready_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       sub_in;

  logic [4:0] in_ready_v;
  logic [4:0] out_valid_v;
  logic [4:0] cout_v;
  logic [4:0] ovf_v;
  logic [4:0] zero_v;
  logic [7:0] sum_0, sum_1;
  logic [3:0] sum_2, sum_3, sum_4;

  int total = 0;
  int bad   = 0;
  int ws[5];
  int ss[5];
  int exp_sum[5];
  bit exp_co[5];
  bit exp_ov[5];
  bit exp_z[5];
  int lat[5];

  always #5 clk = ~clk;

  serial_carry_adder #(.WIDTH(8), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_in), .in_ready(in_ready_v[0]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_in),
    .sum(sum_0), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));
  serial_carry_adder #(.WIDTH(8), .STEP(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_in), .in_ready(in_ready_v[1]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_in),
    .sum(sum_1), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));
  serial_carry_adder #(.WIDTH(4), .STEP(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_in), .in_ready(in_ready_v[2]),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_in),
    .sum(sum_2), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));
  serial_carry_adder #(.WIDTH(4), .STEP(2)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_in), .in_ready(in_ready_v[3]),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_in),
    .sum(sum_3), .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));
  serial_carry_adder #(.WIDTH(4), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_in), .in_ready(in_ready_v[4]),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(out_valid_v[4]), .out_ready(out_ready_in),
    .sum(sum_4), .cout(cout_v[4]), .ovf(ovf_v[4]), .zero(zero_v[4]));

  function automatic logic [7:0] get_sum(input int i);
    case (i)
      0:       return sum_0;
      1:       return sum_1;
      2:       return {4'h0, sum_2};
      3:       return {4'h0, sum_3};
      default: return {4'h0, sum_4};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer add/subtract of unsigned and signed interpretations.
  task automatic ref_op(input int w, input int av, input int bv, input bit ci, input bit sb,
                        output int s, output bit co, output bit ov, output bit z);
    int m, half, ua, sa, sbv, sres, ma, mb;
    m    = 1 << w;
    half = m / 2;
    ma   = av % m;
    mb   = bv % m;
    sa   = (ma >= half) ? ma - m : ma;
    sbv  = (mb >= half) ? mb - m : mb;
    if (!sb) begin
      ua   = ma + mb + int'(ci);
      sres = sa + sbv + int'(ci);
    end else begin
      ua   = ma - mb + m;
      sres = sa - sbv;
    end
    s  = ua % m;
    co = (ua >= m);
    ov = (sres < -half) || (sres >= half);
    z  = (s == 0);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_in_ready[%0d]", tag, i), in_ready_v[i], 1'b1);
      chk($sformatf("%s_out_valid[%0d]", tag, i), out_valid_v[i], 1'b0);
    end
  endtask

  // One operation on all instances; hold = extra DONE cycles with out_ready low.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit ci, input bit sb,
                        input int hold);
    int edges;
    bit all_seen;
    for (int i = 0; i < 5; i++) begin
      ref_op(ws[i], int'(av), int'(bv), ci, sb, exp_sum[i], exp_co[i], exp_ov[i], exp_z[i]);
      lat[i] = 0;
    end
    @(negedge clk);
    check_idle("pre");
    a_in = av; b_in = bv; cin_in = ci; sub_in = sb;
    in_valid_in = 1'b1; out_ready_in = 1'b0;
    @(posedge clk);
    edges = 1;
    all_seen = 1'b0;
    for (int k = 0; k < 20 && !all_seen; k++) begin
      @(negedge clk);
      a_in = 8'($urandom); b_in = 8'($urandom);
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      in_valid_in = 1'($urandom);
      @(posedge clk);
      edges++;
      #1;
      all_seen = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (out_valid_v[i] === 1'b1 && lat[i] == 0) lat[i] = edges;
        if (lat[i] == 0) all_seen = 1'b0;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("sum[%0d]", i), get_sum(i), exp_sum[i]);
        chk($sformatf("cout[%0d]", i), cout_v[i], exp_co[i]);
        chk($sformatf("ovf[%0d]", i), ovf_v[i], exp_ov[i]);
        chk($sformatf("zero[%0d]", i), zero_v[i], exp_z[i]);
        chk($sformatf("out_valid_done[%0d]", i), out_valid_v[i], 1'b1);
        chk($sformatf("in_ready_done[%0d]", i), in_ready_v[i], 1'b0);
        if (h == 0) chk($sformatf("latency[%0d]", i), lat[i], ws[i] / ss[i] + 1);
      end
      a_in = 8'($urandom); b_in = 8'($urandom);
      in_valid_in = (h < hold) ? 1'($urandom) : 1'b1;
      out_ready_in = (h == hold);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_in = 1'b0;
    out_ready_in = 1'b0;
    check_idle("post");
  endtask

  initial begin
    int cnt_ov;
    ws = '{8, 8, 4, 4, 4};
    ss = '{1, 2, 1, 2, 4};
    rst = 1'b1; in_valid_in = 1'b0; out_ready_in = 1'b0;
    a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_sum[%0d]", i), get_sum(i), 8'h00);
      chk($sformatf("rst_cout[%0d]", i), cout_v[i], 1'b0);
      chk($sformatf("rst_ovf[%0d]", i), ovf_v[i], 1'b0);
      chk($sformatf("rst_zero[%0d]", i), zero_v[i], 1'b1);
    end
    check_idle("rst");

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    chk("anchor_7f_plus_1_s2", {sum_1, cout_v[1], ovf_v[1]}, {8'h80, 1'b0, 1'b1});
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 10);
    chk("anchor_5_minus_7_s2", {sum_1, cout_v[1], ovf_v[1]}, {8'hFE, 1'b0, 1'b0});

    // Reset during the third RUN cycle, with in_valid/out_ready also high.
    @(negedge clk);
    a_in = 8'h33; b_in = 8'h44; cin_in = 1'b0; sub_in = 1'b0; in_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid_in = 1'b1; out_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      chk($sformatf("midrst_sum[%0d]", i), get_sum(i), 8'h00);
    check_idle("midrst");
    rst = 1'b0; in_valid_in = 1'b0; out_ready_in = 1'b0;
    cnt_ov = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid_v !== 5'b00000) cnt_ov++;
    end
    chk("no_out_valid_after_rst", cnt_ov, 0);

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++) begin
        for (int ci = 0; ci < 2; ci++)
          run_op({4'($urandom), 4'(av)}, {4'($urandom), 4'(bv)}, 1'(ci), 1'b0, 0);
        run_op({4'($urandom), 4'(av)}, {4'($urandom), 4'(bv)}, 1'($urandom), 1'b1, 0);
      end

    for (int r = 0; r < 60; r++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
